// File: rtl/fifo_arb_pkg.sv
// Shared types for the two-producer FIFO write arbiter: grant states and beat-counter width.
package fifo_arb_pkg;

    localparam int unsigned BEAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // One-hot owner vector seen by the producers; all-zero when nobody holds the grant.
    function automatic logic [1:0] owner_of(arb_state_e s);
        logic [1:0] o;
        o = 2'b00;
        case (s)
            OWN0:    o = 2'b01;
            OWN1:    o = 2'b10;
            default: o = 2'b00;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fifo_wr_arb.sv
// Two-producer burst arbiter feeding one shared FIFO: round-robin bursts of up to BURST_LEN words,
// stalls on full, restarts a burst for a lone requester without dropping to idle.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [1:0]            ack,
    output logic [1:0]            owner
);

    arb_state_e        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic              r_last;

    arb_state_e        w_state_d;
    logic [BEAT_W-1:0] w_beat_d;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_last_d;
    logic              w_cur;
    logic              w_grant_end;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_beat  <= w_beat_d;
            r_last  <= w_last_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_beat_d    = r_beat;
        w_last_d    = r_last;
        w_beat_inc  = r_beat + 1'b1;
        w_cur       = 1'b0;
        w_grant_end = 1'b0;
        wr          = 1'b0;
        ack         = 2'b00;
        owner       = owner_of(r_state);
        w_data      = din0;

        unique case (r_state)
            IDLE: begin
                w_beat_d = '0;
                if (req == 2'b11) begin
                    w_state_d = r_last ? OWN0 : OWN1;
                end else if (req[0]) begin
                    w_state_d = OWN0;
                end else if (req[1]) begin
                    w_state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                w_cur  = (r_state == OWN1);
                w_data = w_cur ? din1 : din0;
                // full freezes everything, including grant hand-over.
                if (!full) begin
                    wr  = req[w_cur];
                    ack = {wr & w_cur, wr & ~w_cur};
                    if (wr) begin
                        w_beat_d = w_beat_inc;
                    end
                    w_grant_end = !req[w_cur] || (w_beat_inc == BEAT_W'(BURST_LEN));
                    if (w_grant_end) begin
                        w_last_d = w_cur;
                        w_beat_d = '0;
                        if (req[~w_cur]) begin
                            w_state_d = w_cur ? OWN0 : OWN1;
                        end else if (!req[w_cur]) begin
                            w_state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
                w_beat_d  = '0;
            end
        endcase
    end

endmodule
